booth_r4_sequencer: RTL



---
 rtl/booth_r4_sequencer_if.sv | 24 ++
 rtl/booth_r4_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/booth_r4_sequencer_if.sv
// Handshake and result bundle between a requester and the radix-4 Booth sequencer.
interface booth_r4_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2:0]           now;
  logic [2*WIDTH-1:0]   product;

  // Requester side: issues start with operands, observes status and result.
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, now, product
  );

  // Sequencer side.
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, now, product
  );
endinterface

// File: rtl/booth_r4_sequencer.sv
// Iterative signed radix-4 Booth multiplier: one 3-bit multiplier window per
// clock, WIDTH x WIDTH -> 2*WIDTH, done pulses for one cycle with the product.
module booth_r4_sequencer #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_r4_sequencer_if.slave   bus
);

  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned KW    = $clog2(STEPS + 1);
  localparam logic [KW-1:0] LAST_K = KW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  // Multiplicand is kept sign-extended and pre-shifted by 2k; multiplier is
  // kept as {mplr, 1'b0} and shifted right by 2 so the current window is
  // always in bits [2:0] (bit 0 supplies the implicit mplr[-1] = 0 at k=0).
  logic [2*WIDTH-1:0]   mc_sh;
  logic [WIDTH:0]       mplr_sh;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   product_q;
  logic [KW-1:0]        k;
  logic [2:0]           window;
  logic                 last_step;
  logic                 accept;

  assign window    = mplr_sh[2:0];
  assign last_step = (k == LAST_K);
  assign accept    = bus.start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next  = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.now     = 3'b000;
    bus.product = product_q;
    unique case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        bus.now  = window;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth recode of the current window into a partial product (already aligned).
  always_comb begin
    pp = '0;
    unique case (window)
      3'b001, 3'b010: pp = mc_sh;
      3'b011:         pp = mc_sh << 1;
      3'b100:         pp = -(mc_sh << 1);
      3'b101, 3'b110: pp = -mc_sh;
      default:        pp = '0;
    endcase
    acc_next = acc + pp;
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_sh     <= '0;
      mplr_sh   <= '0;
      acc       <= '0;
      k         <= '0;
      product_q <= '0;
    end else if (accept) begin
      mc_sh     <= {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      mplr_sh   <= {bus.multiplier, 1'b0};
      acc       <= '0;
      k         <= '0;
    end else if (state == RUN) begin
      mc_sh   <= mc_sh << 2;
      mplr_sh <= mplr_sh >> 2;
      acc     <= acc_next;
      k       <= k + 1'b1;
      if (last_step) product_q <= acc_next;
    end
  end

endmodule
